mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the five-stage pipelined CPU, downstream of the EX/MEM pipeline register and feeding the write-back stage. It issues one data-memory transaction per load/store over a req/ready bus, generating byte lanes from BEOp and the low address bits. It stalls the pipeline while the bus is busy, then sign- or zero-extends load data. It contains the MEM/WB pipeline register, so its outputs are the write-back stage inputs.

## Interface
- DMEM_AW, 32, data-memory byte-address width
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- Signal_mem_i  in  32  control word from EX/MEM; [9:7] BEOp, [10] MemRead, [11] MemWrite
- NPC_mem_i, ALUOut_mem_i, rt_mem_i, EXT_mem_i, RD_mem_i, CD_mem_i  in  32 each  EX/MEM payload; ALUOut is the effective address, rt is the store data
- flush_i  in  1  squash the current MEM instruction
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  DMEM_AW  word-aligned address, {ALUOut[DMEM_AW-1:2],2'b00}
- dmem_be_o  out  4  byte lanes
- dmem_wdata_o  out  32  store data replicated across lanes
- dmem_ready_i  in  1  bus completes the transaction this cycle
- dmem_rdata_i  in  32  read data, valid when ready
- stall_o  out  1  hold IF..EX/MEM this cycle
- Signal_wb_o, NPC_wb_o, ALUOut_wb_o, MemData_wb_o, EXT_wb_o, RD_wb_o, CD_wb_o  out  32 each  MEM/WB register
- addr_exc_o  out  1  misaligned-access exception pulse (MEM_ALIGN_EXC_EN only)
- badvaddr_o  out  32  faulting address (MEM_ALIGN_EXC_EN only)

## Operation
- BEOp: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. Stores ignore signedness. 101–111 are treated as word.
- An access exists when MemRead or MemWrite is set and no flush or exception applies. MemRead and MemWrite both set is treated as a store.
- Byte enables:
  - word: 4'b1111
  - half: 4'b0011 << (2·addr[1])
  - byte: 4'b0001 << addr[1:0]
- Write data: word passes through; half is {2{rt[15:0]}}; byte is {4{rt[7:0]}}.
- Load data: select the lane by addr[1:0], then sign- or zero-extend to 32 bits.
- State machine IDLE/WAIT:
  - IDLE, no access: the MEM/WB register loads the payload every cycle. stall_o = 0.
  - IDLE, access: dmem_req_o = 1 combinationally. If dmem_ready_i = 1, the access completes zero-wait and stall_o = 0. Otherwise stall_o = 1 and the state moves to WAIT.
  - WAIT: dmem_req_o = 1 and address, enables and write data stay stable (taken from the held EX/MEM). When dmem_ready_i = 1, the state returns to IDLE, stall_o = 0 and MEM/WB loads. Otherwise stall_o = 1.
- While stall_o = 1, MEM/WB loads a bubble (Signal_wb = 0). Other payload fields may update.
- flush_i in IDLE: no request is issued; Signal_wb = 0.
- flush_i in WAIT: the bus transaction is not cancelled. A sticky flag is set, and on completion Signal_wb = 0.
- MemData_wb holds extended load data for loads, 0 otherwise.

## Timing
- Zero-wait access or non-memory instruction: one cycle MEM→WB. N wait cycles add N stall cycles.
- stall_o and dmem_req_o are combinational from state, Signal_mem_i and dmem_ready_i. There is no combinational path from dmem_rdata_i to stall_o.
- Reset values:
  - every MEM/WB output 0
  - state IDLE, sticky flush flag 0
  - dmem_req_o 0, stall_o 0, addr_exc_o 0, badvaddr_o 0
- Reset during WAIT: state returns to IDLE on that edge and dmem_req_o drops in the cycle after reset. A late dmem_ready_i is ignored.
- dmem_ready_i while in IDLE with no access is ignored.

## Configuration
- MEM_ALIGN_EXC_EN defined:
  - a word access with addr[1:0] ≠ 0 or a half access with addr[0] ≠ 0 issues no request;
  - addr_exc_o pulses for one cycle, registered with MEM/WB;
  - badvaddr_o captures ALUOut;
  - Signal_wb = 0.
- MEM_ALIGN_EXC_EN undefined:
  - low address bits beyond the lane select are ignored and the access proceeds;
  - addr_exc_o and badvaddr_o are tied to 0.

## Structure
- Shared package `cpu_pkg`: BEOp encodings, Signal bit positions (BEOp 9:7, MemRead 10, MemWrite 11), state enum, Cause codes.
- One sub-module, `mem_lane_align`: combinational byte-enable generation, store replication and load extract/extend.
- FSM and MEM/WB register live in the top.

## Test plan
- sw at addr 0x10, rt=0xDEADBEEF, ready same cycle → be=1111, wdata=DEADBEEF, stall_o never high.
- lb at addr 0x13, rdata=0x80xxxxxx, ready after 3 cycles → be=1000, stall_o high 3 cycles, 3 bubbles, then MemData_wb=0xFFFFFF80.
- lhu at addr 0x22, rdata=0x8001xxxx → be=1100, MemData_wb=0x00008001.
- sh at addr 0x21 with MEM_ALIGN_EXC_EN → no req, addr_exc_o=1 for one cycle, badvaddr_o=0x21, Signal_wb=0. Without the macro: be=0011.
- flush_i during WAIT of lw, ready 2 cycles later → req held until ready, then Signal_wb=0.
- rst asserted in WAIT → next cycle state IDLE, req=0, all outputs 0; a ready arriving afterwards has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word bit positions, BEOp encodings,
// MEM-stage FSM states, access-size helper, exception cause codes and
// the MEM/WB payload struct.
package cpu_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned SIG_BEOP_LSB = 7;
   localparam int unsigned SIG_BEOP_MSB = 9;
   localparam int unsigned SIG_MEMREAD  = 10;
   localparam int unsigned SIG_MEMWRITE = 11;

   // BEOp encodings carried in Signal[9:7]; 101..111 decode as word
   typedef enum logic [2:0] {
      BE_WORD   = 3'b000,
      BE_HALF_S = 3'b001,
      BE_HALF_U = 3'b010,
      BE_BYTE_S = 3'b011,
      BE_BYTE_U = 3'b100
   } beop_e;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_HALF = 2'd1,
      SZ_BYTE = 2'd2
   } acc_size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   // Exception cause codes for address errors on load / store
   localparam logic [4:0] CAUSE_ADEL = 5'd4;
   localparam logic [4:0] CAUSE_ADES = 5'd5;

   // MEM/WB pipeline register payload
   typedef struct packed {
      logic [XLEN-1:0] signal;
      logic [XLEN-1:0] npc;
      logic [XLEN-1:0] aluout;
      logic [XLEN-1:0] memdata;
      logic [XLEN-1:0] ext;
      logic [XLEN-1:0] rd;
      logic [XLEN-1:0] cd;
   } mem_wb_t;

   // Access size implied by BEOp (signedness dropped)
   function automatic acc_size_e beop_size(input logic [2:0] beop);
      acc_size_e sz;
      case (beop)
         BE_HALF_S, BE_HALF_U: sz = SZ_HALF;
         BE_BYTE_S, BE_BYTE_U: sz = SZ_BYTE;
         default:              sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   // Natural-alignment violation for the given BEOp and low address bits
   function automatic logic is_misaligned(input logic [2:0] beop, input logic [1:0] addr_lo);
      logic bad;
      case (beop_size(beop))
         SZ_WORD: bad = (addr_lo != 2'b00);
         SZ_HALF: bad = addr_lo[0];
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the MEM stage: byte enables, store-data
// replication and load-data lane extract with sign/zero extension.
module mem_lane_align
   import cpu_pkg::*;
(
   input  logic [2:0]      beop_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] wdata_raw_i,
   input  logic [XLEN-1:0] rdata_raw_i,
   output logic [3:0]      be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_ext_o
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;
   logic        is_signed;

   // Lane enables and replicated store data from access size and address
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_raw_i;
      case (beop_size(beop_i))
         SZ_HALF: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_raw_i[15:0]}};
         end
         SZ_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_raw_i[7:0]}};
         end
         default: begin
            be_o    = 4'b1111;
            wdata_o = wdata_raw_i;
         end
      endcase
   end

   // Pick the addressed lane of read data and extend to full width
   always_comb begin
      half_sel    = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];
      byte_sel    = rdata_raw_i[7:0];
      case (addr_lo_i)
         2'd1:    byte_sel = rdata_raw_i[15:8];
         2'd2:    byte_sel = rdata_raw_i[23:16];
         2'd3:    byte_sel = rdata_raw_i[31:24];
         default: byte_sel = rdata_raw_i[7:0];
      endcase
      is_signed   = (beop_i == BE_HALF_S) || (beop_i == BE_BYTE_S);
      rdata_ext_o = rdata_raw_i;
      case (beop_size(beop_i))
         SZ_HALF: rdata_ext_o = {{16{is_signed & half_sel[15]}}, half_sel};
         SZ_BYTE: rdata_ext_o = {{24{is_signed & byte_sel[7]}}, byte_sel};
         default: rdata_ext_o = rdata_raw_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one data-memory transaction per
// load/store over a req/ready bus, stalls upstream while the bus is busy,
// and holds the MEM/WB pipeline register.
// Optional feature macro: MEM_ALIGN_EXC_EN (misaligned-access exception).
module mem_access_stage
   import cpu_pkg::*;
#(
   parameter int unsigned DMEM_AW = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XLEN-1:0]    Signal_mem_i,
   input  logic [XLEN-1:0]    NPC_mem_i,
   input  logic [XLEN-1:0]    ALUOut_mem_i,
   input  logic [XLEN-1:0]    rt_mem_i,
   input  logic [XLEN-1:0]    EXT_mem_i,
   input  logic [XLEN-1:0]    RD_mem_i,
   input  logic [XLEN-1:0]    CD_mem_i,
   input  logic               flush_i,
   output logic               dmem_req_o,
   output logic               dmem_we_o,
   output logic [DMEM_AW-1:0] dmem_addr_o,
   output logic [3:0]         dmem_be_o,
   output logic [XLEN-1:0]    dmem_wdata_o,
   input  logic               dmem_ready_i,
   input  logic [XLEN-1:0]    dmem_rdata_i,
   output logic               stall_o,
   output logic [XLEN-1:0]    Signal_wb_o,
   output logic [XLEN-1:0]    NPC_wb_o,
   output logic [XLEN-1:0]    ALUOut_wb_o,
   output logic [XLEN-1:0]    MemData_wb_o,
   output logic [XLEN-1:0]    EXT_wb_o,
   output logic [XLEN-1:0]    RD_wb_o,
   output logic [XLEN-1:0]    CD_wb_o,
   output logic               addr_exc_o,
   output logic [XLEN-1:0]    badvaddr_o
);

   logic [2:0]      beop;
   logic            mem_rd;
   logic            mem_wr;
   logic            is_mem;
   logic            is_load;
   logic            misalign;
   logic [XLEN-1:0] rdata_ext;

   mem_state_e      state_q, state_d;
   logic            flush_seen_q, flush_seen_d;
   mem_wb_t         mem_wb_q, mem_wb_d;
   logic            done;
   logic            kill;

   assign beop    = Signal_mem_i[SIG_BEOP_MSB:SIG_BEOP_LSB];
   assign mem_rd  = Signal_mem_i[SIG_MEMREAD];
   assign mem_wr  = Signal_mem_i[SIG_MEMWRITE];
   assign is_mem  = mem_rd | mem_wr;
   assign is_load = mem_rd & ~mem_wr;

`ifdef MEM_ALIGN_EXC_EN
   assign misalign = is_misaligned(beop, ALUOut_mem_i[1:0]);
`else
   assign misalign = 1'b0;
`endif

   // Lane logic; address/data come from the held EX/MEM so they stay stable in WAIT
   mem_lane_align u_lane (
      .beop_i      (beop),
      .addr_lo_i   (ALUOut_mem_i[1:0]),
      .wdata_raw_i (rt_mem_i),
      .rdata_raw_i (dmem_rdata_i),
      .be_o        (dmem_be_o),
      .wdata_o     (dmem_wdata_o),
      .rdata_ext_o (rdata_ext)
   );

   assign dmem_addr_o = {ALUOut_mem_i[DMEM_AW-1:2], 2'b00};
   assign dmem_we_o   = dmem_req_o & mem_wr;

   // Bus handshake, stall generation, FSM next state and MEM/WB next value
   always_comb begin
      state_d      = state_q;
      flush_seen_d = flush_seen_q;
      dmem_req_o   = 1'b0;
      stall_o      = 1'b0;
      done         = 1'b0;
      kill         = flush_i;
      case (state_q)
         ST_IDLE: begin
            kill = flush_i | misalign;
            if (is_mem && !flush_i && !misalign) begin
               dmem_req_o = 1'b1;
               if (dmem_ready_i) begin
                  done = 1'b1;
               end else begin
                  stall_o = 1'b1;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // A flush here cannot cancel the bus cycle; remember it for completion
            dmem_req_o = 1'b1;
            kill       = flush_seen_q | flush_i;
            if (dmem_ready_i) begin
               done         = 1'b1;
               state_d      = ST_IDLE;
               flush_seen_d = 1'b0;
            end else begin
               stall_o      = 1'b1;
               flush_seen_d = flush_seen_q | flush_i;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (rst) begin
         dmem_req_o = 1'b0;
         stall_o    = 1'b0;
      end

      mem_wb_d.signal  = (stall_o || kill) ? '0 : Signal_mem_i;
      mem_wb_d.npc     = NPC_mem_i;
      mem_wb_d.aluout  = ALUOut_mem_i;
      mem_wb_d.memdata = (done && is_load && !kill) ? rdata_ext : '0;
      mem_wb_d.ext     = EXT_mem_i;
      mem_wb_d.rd      = RD_mem_i;
      mem_wb_d.cd      = CD_mem_i;
   end

   // FSM state, sticky flush flag and MEM/WB register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         flush_seen_q <= 1'b0;
         mem_wb_q     <= '0;
      end else begin
         state_q      <= state_d;
         flush_seen_q <= flush_seen_d;
         mem_wb_q     <= mem_wb_d;
      end
   end

   assign Signal_wb_o  = mem_wb_q.signal;
   assign NPC_wb_o     = mem_wb_q.npc;
   assign ALUOut_wb_o  = mem_wb_q.aluout;
   assign MemData_wb_o = mem_wb_q.memdata;
   assign EXT_wb_o     = mem_wb_q.ext;
   assign RD_wb_o      = mem_wb_q.rd;
   assign CD_wb_o      = mem_wb_q.cd;

`ifdef MEM_ALIGN_EXC_EN
   logic            addr_exc_q, addr_exc_d;
   logic [XLEN-1:0] badvaddr_q, badvaddr_d;

   // Misaligned access detected in IDLE raises a one-cycle exception pulse
   always_comb begin
      addr_exc_d = (state_q == ST_IDLE) && is_mem && !flush_i && misalign;
      badvaddr_d = addr_exc_d ? ALUOut_mem_i : badvaddr_q;
   end

   // Exception pulse and faulting address, aligned with MEM/WB
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_exc_q <= 1'b0;
         badvaddr_q <= '0;
      end else begin
         addr_exc_q <= addr_exc_d;
         badvaddr_q <= badvaddr_d;
      end
   end

   assign addr_exc_o = addr_exc_q;
   assign badvaddr_o = badvaddr_q;
`else
   assign addr_exc_o = 1'b0;
   assign badvaddr_o = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

   logic        clk;
   logic        rst;
   logic [31:0] Signal_mem_i, NPC_mem_i, ALUOut_mem_i, rt_mem_i;
   logic [31:0] EXT_mem_i, RD_mem_i, CD_mem_i;
   logic        flush_i;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ready_i;
   logic [31:0] dmem_rdata_i;
   logic        stall_o;
   logic [31:0] Signal_wb_o, NPC_wb_o, ALUOut_wb_o, MemData_wb_o;
   logic [31:0] EXT_wb_o, RD_wb_o, CD_wb_o;
   logic        addr_exc_o;
   logic [31:0] badvaddr_o;

   int checks;
   int errors;

   mem_access_stage #(.DMEM_AW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .Signal_mem_i (Signal_mem_i),
      .NPC_mem_i    (NPC_mem_i),
      .ALUOut_mem_i (ALUOut_mem_i),
      .rt_mem_i     (rt_mem_i),
      .EXT_mem_i    (EXT_mem_i),
      .RD_mem_i     (RD_mem_i),
      .CD_mem_i     (CD_mem_i),
      .flush_i      (flush_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_be_o    (dmem_be_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_ready_i (dmem_ready_i),
      .dmem_rdata_i (dmem_rdata_i),
      .stall_o      (stall_o),
      .Signal_wb_o  (Signal_wb_o),
      .NPC_wb_o     (NPC_wb_o),
      .ALUOut_wb_o  (ALUOut_wb_o),
      .MemData_wb_o (MemData_wb_o),
      .EXT_wb_o     (EXT_wb_o),
      .RD_wb_o      (RD_wb_o),
      .CD_wb_o      (CD_wb_o),
      .addr_exc_o   (addr_exc_o),
      .badvaddr_o   (badvaddr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] sig(input logic [2:0] beop, input logic rd, input logic wr);
      return {20'h0, wr, rd, beop, 7'h05};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      Signal_mem_i = '0; NPC_mem_i = '0; ALUOut_mem_i = '0; rt_mem_i = '0;
      EXT_mem_i = '0; RD_mem_i = '0; CD_mem_i = '0; flush_i = 1'b0;
      dmem_ready_i = 1'b0; dmem_rdata_i = '0;
      tick(); tick();

      // reset state
      check("rst_sig",   Signal_wb_o, 32'h0);
      check("rst_npc",   NPC_wb_o, 32'h0);
      check("rst_mdata", MemData_wb_o, 32'h0);
      check("rst_req",   {31'h0, dmem_req_o}, 32'h0);
      check("rst_stall", {31'h0, stall_o}, 32'h0);
      check("rst_exc",   {31'h0, addr_exc_o}, 32'h0);
      check("rst_bva",   badvaddr_o, 32'h0);
      rst = 1'b0;

      // sw 0x10, zero-wait
      Signal_mem_i = sig(3'b000, 1'b0, 1'b1); ALUOut_mem_i = 32'h10;
      rt_mem_i = 32'hDEADBEEF; NPC_mem_i = 32'h104; EXT_mem_i = 32'h77;
      RD_mem_i = 32'h3; CD_mem_i = 32'h9; dmem_ready_i = 1'b1;
      settle();
      check("sw_req",   {31'h0, dmem_req_o}, 32'h1);
      check("sw_we",    {31'h0, dmem_we_o}, 32'h1);
      check("sw_be",    {28'h0, dmem_be_o}, 32'hF);
      check("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
      check("sw_addr",  dmem_addr_o, 32'h10);
      check("sw_stall", {31'h0, stall_o}, 32'h0);
      tick();
      check("sw_sigwb", Signal_wb_o, sig(3'b000, 1'b0, 1'b1));
      check("sw_npcwb", NPC_wb_o, 32'h104);
      check("sw_aluwb", ALUOut_wb_o, 32'h10);
      check("sw_extwb", EXT_wb_o, 32'h77);
      check("sw_mdwb",  MemData_wb_o, 32'h0);

      // non-memory op, stray ready ignored
      Signal_mem_i = 32'h5; ALUOut_mem_i = 32'h1234; dmem_ready_i = 1'b1;
      settle();
      check("alu_req",   {31'h0, dmem_req_o}, 32'h0);
      check("alu_stall", {31'h0, stall_o}, 32'h0);
      tick();
      check("alu_sigwb", Signal_wb_o, 32'h5);
      check("alu_aluwb", ALUOut_wb_o, 32'h1234);

      // lb 0x13, three wait cycles
      Signal_mem_i = sig(3'b011, 1'b1, 1'b0); ALUOut_mem_i = 32'h13;
      dmem_rdata_i = 32'h80123456; dmem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("lb_stall", {31'h0, stall_o}, 32'h1);
         check("lb_req",   {31'h0, dmem_req_o}, 32'h1);
         check("lb_be",    {28'h0, dmem_be_o}, 32'h8);
         tick();
         check("lb_bubble", Signal_wb_o, 32'h0);
      end
      dmem_ready_i = 1'b1;
      settle();
      check("lb_done_stall", {31'h0, stall_o}, 32'h0);
      check("lb_done_we",    {31'h0, dmem_we_o}, 32'h0);
      tick();
      check("lb_sigwb", Signal_wb_o, sig(3'b011, 1'b1, 1'b0));
      check("lb_mdwb",  MemData_wb_o, 32'hFFFFFF80);
      Signal_mem_i = 32'h0; dmem_ready_i = 1'b0;
      settle();
      check("lb_idle_req", {31'h0, dmem_req_o}, 32'h0);
      tick();

      // lhu 0x22
      Signal_mem_i = sig(3'b010, 1'b1, 1'b0); ALUOut_mem_i = 32'h22;
      dmem_rdata_i = 32'h80011234; dmem_ready_i = 1'b1;
      settle();
      check("lhu_be",   {28'h0, dmem_be_o}, 32'hC);
      check("lhu_addr", dmem_addr_o, 32'h20);
      tick();
      check("lhu_mdwb", MemData_wb_o, 32'h00008001);

      // lh 0x20 signed
      Signal_mem_i = sig(3'b001, 1'b1, 1'b0); ALUOut_mem_i = 32'h20;
      dmem_rdata_i = 32'h12348001;
      settle();
      check("lh_be", {28'h0, dmem_be_o}, 32'h3);
      tick();
      check("lh_mdwb", MemData_wb_o, 32'hFFFF8001);

      // lbu 0x11
      Signal_mem_i = sig(3'b100, 1'b1, 1'b0); ALUOut_mem_i = 32'h11;
      dmem_rdata_i = 32'h0000A500;
      settle();
      check("lbu_be", {28'h0, dmem_be_o}, 32'h2);
      tick();
      check("lbu_mdwb", MemData_wb_o, 32'h000000A5);

      // sb 0x12
      Signal_mem_i = sig(3'b011, 1'b0, 1'b1); ALUOut_mem_i = 32'h12;
      rt_mem_i = 32'h123456AB;
      settle();
      check("sb_be",    {28'h0, dmem_be_o}, 32'h4);
      check("sb_wdata", dmem_wdata_o, 32'hABABABAB);
      tick();
      check("sb_mdwb", MemData_wb_o, 32'h0);

      // sh 0x21, misaligned half store
      Signal_mem_i = sig(3'b001, 1'b0, 1'b1); ALUOut_mem_i = 32'h21;
      rt_mem_i = 32'h0000CAFE;
      settle();
`ifdef MEM_ALIGN_EXC_EN
      check("shx_req", {31'h0, dmem_req_o}, 32'h0);
      tick();
      check("shx_exc",   {31'h0, addr_exc_o}, 32'h1);
      check("shx_bva",   badvaddr_o, 32'h21);
      check("shx_sigwb", Signal_wb_o, 32'h0);
      Signal_mem_i = 32'h0;
      tick();
      check("shx_exc_pulse", {31'h0, addr_exc_o}, 32'h0);
      check("shx_bva_hold",  badvaddr_o, 32'h21);
`else
      check("sh_req",   {31'h0, dmem_req_o}, 32'h1);
      check("sh_be",    {28'h0, dmem_be_o}, 32'h3);
      check("sh_wdata", dmem_wdata_o, 32'hCAFECAFE);
      tick();
      check("sh_exc",   {31'h0, addr_exc_o}, 32'h0);
      check("sh_bva",   badvaddr_o, 32'h0);
      check("sh_sigwb", Signal_wb_o, sig(3'b001, 1'b0, 1'b1));
`endif

      // flush in IDLE: no request, bubble
      Signal_mem_i = sig(3'b000, 1'b1, 1'b0); ALUOut_mem_i = 32'h30;
      flush_i = 1'b1; dmem_ready_i = 1'b0;
      settle();
      check("fli_req",   {31'h0, dmem_req_o}, 32'h0);
      check("fli_stall", {31'h0, stall_o}, 32'h0);
      tick();
      check("fli_sigwb", Signal_wb_o, 32'h0);
      flush_i = 1'b0;

      // lw 0x40, flush during WAIT, ready two cycles later
      ALUOut_mem_i = 32'h40; dmem_rdata_i = 32'h11223344;
      settle();
      check("flw_stall0", {31'h0, stall_o}, 32'h1);
      tick();
      flush_i = 1'b1;
      settle();
      check("flw_req1",   {31'h0, dmem_req_o}, 32'h1);
      check("flw_stall1", {31'h0, stall_o}, 32'h1);
      tick();
      flush_i = 1'b0;
      settle();
      check("flw_req2", {31'h0, dmem_req_o}, 32'h1);
      tick();
      dmem_ready_i = 1'b1;
      settle();
      check("flw_req3",   {31'h0, dmem_req_o}, 32'h1);
      check("flw_stall3", {31'h0, stall_o}, 32'h0);
      tick();
      check("flw_sigwb", Signal_wb_o, 32'h0);
      check("flw_mdwb",  MemData_wb_o, 32'h0);
      // sticky flag must be clear for the next load
      settle();
      tick();
      check("flw_next_sigwb", Signal_wb_o, sig(3'b000, 1'b1, 1'b0));
      check("flw_next_mdwb",  MemData_wb_o, 32'h11223344);

      // reset while in WAIT
      Signal_mem_i = sig(3'b000, 1'b1, 1'b0); ALUOut_mem_i = 32'h50;
      dmem_ready_i = 1'b0;
      settle();
      check("rw_stall", {31'h0, stall_o}, 32'h1);
      tick();
      rst = 1'b1; Signal_mem_i = 32'h0; NPC_mem_i = 32'h0; ALUOut_mem_i = 32'h0;
      EXT_mem_i = 32'h0; RD_mem_i = 32'h0; CD_mem_i = 32'h0;
      tick();
      rst = 1'b0;
      settle();
      check("rw_req",   {31'h0, dmem_req_o}, 32'h0);
      check("rw_stall2", {31'h0, stall_o}, 32'h0);
      check("rw_sigwb", Signal_wb_o, 32'h0);
      check("rw_npcwb", NPC_wb_o, 32'h0);
      check("rw_mdwb",  MemData_wb_o, 32'h0);
      dmem_ready_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
      settle();
      check("rw_late_req", {31'h0, dmem_req_o}, 32'h0);
      tick();
      check("rw_late_mdwb", MemData_wb_o, 32'h0);
      check("rw_late_sig",  Signal_wb_o, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
